mem_result_reader: RTL and testbench
====================================

Name: mem_result_reader

Overview:
- Read-side counterpart to the compute circuit, which writes 32-bit result words into the 128-word memory and then asserts done.
- On start (normally wired to the circuit's done), this block walks a contiguous memory window and presents each word on a valid/ready output stream.
- It is used for bench scoreboarding and as the result-drain path for the top level.
- It shares the memory's index/read-data port through an external mux. It never writes memory.

Parameters:
- ADDR_W, 7, memory index width (128 words).
- DATA_W, 32, memory word width.
- BASE, 0, first index read.
- COUNT, 128, number of words read per run; legal range 1..2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous and active-low. rst=0 resets the block immediately.
- start  in  1  begin a run; sampled only in IDLE.
- mem_index  out  ADDR_W  memory read index.
- mem_rd  out  1  high while this block owns the memory port; drives the external mux select.
- mem_out  in  DATA_W  memory read data, valid 1 cycle after mem_index is presented (synchronous read).
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_W  word read from memory.
- out_index  out  ADDR_W  memory index that out_data came from.
- out_last  out  1  marks the final word of the run; qualified by out_valid.
- busy  out  1  high in every state except IDLE.
- rd_done  out  1  single-cycle pulse after the last word is accepted.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. All outputs are 0: mem_index, mem_rd, out_valid, out_data, out_index, out_last, busy, rd_done. The internal counter is 0.
- A reset in the middle of a run aborts it. There is no partial rd_done.
- FSM states: IDLE, ISSUE, CAPTURE, PRESENT, FINISH.
- IDLE:
  - On start=1: addr<=BASE, cnt<=0, next state ISSUE.
  - start=0: stay in IDLE.
- ISSUE:
  - mem_index=addr, mem_rd=1.
  - Next state CAPTURE unconditionally.
- CAPTURE:
  - mem_rd=1, mem_index held at addr.
  - At the end of the cycle: out_data<=mem_out, out_index<=addr, out_last<=(cnt==COUNT-1).
  - Next state PRESENT.
- PRESENT:
  - out_valid=1; mem_rd=0.
  - out_data, out_index and out_last stay stable until the transfer completes (out_valid & out_ready).
  - On transfer with out_last=1: next state FINISH.
  - On transfer otherwise: addr<=addr+1, cnt<=cnt+1, next state ISSUE.
  - No transfer: stay in PRESENT (stall of any length).
- FINISH:
  - rd_done=1 for exactly this cycle; out_valid=0.
  - Next state IDLE.
- Latency: start to first out_valid is 3 cycles. Steady-state throughput with out_ready held at 1 is one word per 3 cycles.
- Address arithmetic is modulo 2^ADDR_W. A window with BASE+COUNT>128 wraps to index 0.
- cnt is ADDR_W+1 bits wide so that COUNT=128 is representable.
- start while busy=1 is ignored; no queuing.
- start asserted in the FINISH cycle is ignored.
- start in the IDLE cycle directly after FINISH begins a new run.
- out_ready has no effect outside PRESENT.
- mem_rd is high only in ISSUE and CAPTURE. The memory write-enable must stay 0 whenever mem_rd=1; the external mux guarantees this.
- out_valid never drops without a transfer, except on reset.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, ISSUE, CAPTURE, PRESENT, FINISH);
  - MEM_ADDR_W=7 and MEM_DATA_W=32, which are also used by circuit and memory.
- No sub-module. The address/count logic and the FSM live in one module.
- The port-sharing mux is a separate top-level concern and is out of scope here.

Test Plan:
- Basic run: preload mem[i]=i*3+1, BASE=0, COUNT=4, out_ready=1, pulse start.
  - First out_valid exactly 3 cycles after start.
  - Data sequence 1, 4, 7, 10 with out_index 0..3.
  - out_last only on the 4th word.
  - rd_done pulses one cycle after the last transfer, then busy=0.
- Backpressure: out_ready=0 for 5 cycles on word 2.
  - out_data=7 and out_index=2 stay stable for the whole stall.
  - No mem_rd during the stall; no words lost or duplicated.
- Wrap-around: BASE=126, COUNT=4, mem[126..127]=0xAAAA0001/0xAAAA0002, mem[0..1]=0xBBBB0001/0xBBBB0002.
  - out_index sequence is 126, 127, 0, 1 with matching data.
- Full window: BASE=0, COUNT=128.
  - 128 transfers; out_last only at index 127.
  - Exactly one rd_done pulse.
- Start while busy: pulse start again during word 1.
  - Run length is unchanged (4 words) and no restart occurs.
  - A start one cycle after rd_done begins a new run from BASE.
- Mid-run reset: drive rst=0 asynchronously (between clock edges) while in PRESENT.
  - All outputs go to 0 immediately and no rd_done occurs.
  - After rst returns to 1, a fresh start produces the complete sequence from BASE.

Source files
------------

// File: rtl/mem_result_reader_pkg.sv
// Shared definitions for the result-drain path: memory geometry and the reader FSM states.
package mem_result_reader_pkg;

    localparam int MEM_ADDR_W = 7;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        PRESENT,
        FINISH
    } state_e;

endpackage

// File: rtl/mem_result_reader.sv
// Walks a contiguous window of the result memory and streams each word out over valid/ready.
// One word costs three cycles: present index, capture read data, hand off downstream.
module mem_result_reader
    import mem_result_reader_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W,
    parameter int BASE   = 0,
    parameter int COUNT  = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_index,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              out_last,
    output logic              busy,
    output logic              rd_done
);

    localparam logic [ADDR_W-1:0] BASE_IDX = ADDR_W'(BASE);
    // cnt carries one extra bit so a full 2^ADDR_W window has a representable last count.
    localparam logic [ADDR_W:0]   LAST_CNT = (ADDR_W + 1)'(COUNT - 1);

    state_e              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     cnt_q;
    logic                mem_rd_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [ADDR_W-1:0]   out_index_q;
    logic                out_last_q;
    logic                busy_q;
    logic                rd_done_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            mem_rd_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            rd_done_q   <= 1'b0;
        end else begin
            rd_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q   <= BASE_IDX;
                        cnt_q    <= '0;
                        mem_rd_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= CAPTURE;
                end
                CAPTURE: begin
                    out_data_q  <= mem_out;
                    out_index_q <= addr_q;
                    out_last_q  <= (cnt_q == LAST_CNT);
                    out_valid_q <= 1'b1;
                    mem_rd_q    <= 1'b0;
                    state_q     <= PRESENT;
                end
                PRESENT: begin
                    // Hold the word until it is taken; the address only moves on a transfer.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (out_last_q) begin
                            rd_done_q <= 1'b1;
                            state_q   <= FINISH;
                        end else begin
                            addr_q   <= addr_q + 1'b1;
                            cnt_q    <= cnt_q + 1'b1;
                            mem_rd_q <= 1'b1;
                            state_q  <= ISSUE;
                        end
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_index = addr_q;
    assign mem_rd    = mem_rd_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_index = out_index_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign rd_done   = rd_done_q;

endmodule

// File: tb/tb_mem_result_reader.sv
// Directed bench: three reader instances (short window, wrapping window, full window) on shared clk/rst.
module tb_mem_result_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mem_lin  [128];
    logic [31:0] mem_wrap [128];

    // instance a: BASE=0 COUNT=4
    logic        start_a = 0, ready_a = 1, mem_rd_a, valid_a, last_a, busy_a, rd_done_a;
    logic [6:0]  mem_index_a, index_a;
    logic [31:0] mem_out_a, data_a;
    // instance w: BASE=126 COUNT=4
    logic        start_w = 0, ready_w = 1, mem_rd_w, valid_w, last_w, busy_w, rd_done_w;
    logic [6:0]  mem_index_w, index_w;
    logic [31:0] mem_out_w, data_w;
    // instance f: BASE=0 COUNT=128
    logic        start_f = 0, ready_f = 1, mem_rd_f, valid_f, last_f, busy_f, rd_done_f;
    logic [6:0]  mem_index_f, index_f;
    logic [31:0] mem_out_f, data_f;

    mem_result_reader #(.ADDR_W(7), .DATA_W(32), .BASE(0), .COUNT(4)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .mem_index(mem_index_a), .mem_rd(mem_rd_a),
        .mem_out(mem_out_a), .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
        .out_index(index_a), .out_last(last_a), .busy(busy_a), .rd_done(rd_done_a));
    mem_result_reader #(.ADDR_W(7), .DATA_W(32), .BASE(126), .COUNT(4)) u_w (
        .clk(clk), .rst(rst), .start(start_w), .mem_index(mem_index_w), .mem_rd(mem_rd_w),
        .mem_out(mem_out_w), .out_valid(valid_w), .out_ready(ready_w), .out_data(data_w),
        .out_index(index_w), .out_last(last_w), .busy(busy_w), .rd_done(rd_done_w));
    mem_result_reader #(.ADDR_W(7), .DATA_W(32), .BASE(0), .COUNT(128)) u_f (
        .clk(clk), .rst(rst), .start(start_f), .mem_index(mem_index_f), .mem_rd(mem_rd_f),
        .mem_out(mem_out_f), .out_valid(valid_f), .out_ready(ready_f), .out_data(data_f),
        .out_index(index_f), .out_last(last_f), .busy(busy_f), .rd_done(rd_done_f));

    // Synchronous-read memory models
    always @(posedge clk) begin
        mem_out_a <= mem_lin[mem_index_a];
        mem_out_w <= mem_wrap[mem_index_w];
        mem_out_f <= mem_lin[mem_index_f];
    end

    logic [31:0] dat_a[$], dat_w[$], dat_f[$];
    logic [6:0]  idx_a[$], idx_w[$], idx_f[$];
    logic        lst_a[$], lst_w[$], lst_f[$];
    int          xcyc_a[$];
    int          done_cnt_a = 0, done_cnt_w = 0, done_cnt_f = 0, done_cyc_a = 0;

    // Transfers are recorded on the falling edge, half a cycle before the accepting rising edge.
    always @(negedge clk) begin
        if (rst) begin
            if (valid_a && ready_a) begin
                dat_a.push_back(data_a); idx_a.push_back(index_a); lst_a.push_back(last_a);
                xcyc_a.push_back(cyc);
                $display("xfer a idx=%0d data=%08h last=%0d", index_a, data_a, last_a);
            end
            if (valid_w && ready_w) begin
                dat_w.push_back(data_w); idx_w.push_back(index_w); lst_w.push_back(last_w);
                $display("xfer w idx=%0d data=%08h last=%0d", index_w, data_w, last_w);
            end
            if (valid_f && ready_f) begin
                dat_f.push_back(data_f); idx_f.push_back(index_f); lst_f.push_back(last_f);
                $display("xfer f idx=%0d data=%08h last=%0d", index_f, data_f, last_f);
            end
            if (rd_done_a) begin done_cnt_a++; done_cyc_a = cyc; end
            if (rd_done_w) done_cnt_w++;
            if (rd_done_f) done_cnt_f++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        dat_a.delete(); idx_a.delete(); lst_a.delete(); xcyc_a.delete();
    endtask

    // Waits until rd_done of the selected instance is seen; returns in the FINISH cycle.
    task automatic wait_done(input int which, input int limit, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            tick();
            if ((which == 0 && rd_done_a) || (which == 1 && rd_done_w) || (which == 2 && rd_done_f)) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_done_seen"}, seen, 1'b1);
    endtask

    task automatic wait_present_a(input logic [6:0] idx, input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_a && index_a == idx) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_present_seen"}, seen, 1'b1);
    endtask

    logic [31:0] exp_lin [4] = '{32'd1, 32'd4, 32'd7, 32'd10};

    task automatic check_seq_a(input string tag);
        chk({tag, "_count"}, dat_a.size(), 4);
        for (int i = 0; i < 4 && i < dat_a.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), dat_a[i], exp_lin[i]);
            chk($sformatf("%s_idx%0d", tag, i), idx_a[i], i);
            chk($sformatf("%s_last%0d", tag, i), lst_a[i], (i == 3));
        end
    endtask

    logic [6:0]  exp_w_idx [4] = '{7'd126, 7'd127, 7'd0, 7'd1};
    logic [31:0] exp_w_dat [4] = '{32'hAAAA0001, 32'hAAAA0002, 32'hBBBB0001, 32'hBBBB0002};

    initial begin
        int saved_done, bad_idx, bad_dat, n_last;

        for (int i = 0; i < 128; i++) begin
            mem_lin[i]  = i * 3 + 1;
            mem_wrap[i] = 32'hDEAD0000 | i;
        end
        mem_wrap[126] = 32'hAAAA0001;
        mem_wrap[127] = 32'hAAAA0002;
        mem_wrap[0]   = 32'hBBBB0001;
        mem_wrap[1]   = 32'hBBBB0002;

        // Reset state
        #2 rst = 1'b0;
        tick(); tick();
        chk("rst_busy", busy_a, 0);
        chk("rst_valid", valid_a, 0);
        chk("rst_mem_rd", mem_rd_a, 0);
        chk("rst_mem_index", mem_index_a, 0);
        chk("rst_data", data_a, 0);
        chk("rst_rd_done", rd_done_a, 0);
        rst = 1'b1;
        tick();

        // Basic run with latency and handshake timing
        clear_a();
        start_a = 1; tick(); start_a = 0;
        chk("t1_issue_busy", busy_a, 1);
        chk("t1_issue_mem_rd", mem_rd_a, 1);
        chk("t1_issue_index", mem_index_a, 0);
        chk("t1_issue_valid", valid_a, 0);
        tick();
        chk("t1_capture_valid", valid_a, 0);
        chk("t1_capture_mem_rd", mem_rd_a, 1);
        tick();
        chk("t1_first_valid", valid_a, 1);
        chk("t1_first_data", data_a, 1);
        chk("t1_present_mem_rd", mem_rd_a, 0);
        wait_done(0, 40, "t1");
        chk("t1_finish_valid", valid_a, 0);
        chk("t1_finish_busy", busy_a, 1);
        tick();
        chk("t1_idle_rd_done", rd_done_a, 0);
        chk("t1_idle_busy", busy_a, 0);
        check_seq_a("t1");
        if (xcyc_a.size() == 4) begin
            chk("t1_throughput", xcyc_a[1] - xcyc_a[0], 3);
            chk("t1_done_after_last", done_cyc_a - xcyc_a[3], 1);
        end else begin
            chk("t1_xfer_cycles", xcyc_a.size(), 4);
        end
        chk("t1_done_cnt", done_cnt_a, 1);

        // Backpressure on word 2
        clear_a();
        start_a = 1; tick(); start_a = 0;
        wait_present_a(7'd2, "t2");
        ready_a = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("t2_stall%0d_valid", i), valid_a, 1);
            chk($sformatf("t2_stall%0d_data", i), data_a, 7);
            chk($sformatf("t2_stall%0d_index", i), index_a, 2);
            chk($sformatf("t2_stall%0d_mem_rd", i), mem_rd_a, 0);
        end
        ready_a = 1;
        wait_done(0, 40, "t2");
        tick();
        check_seq_a("t2");
        chk("t2_done_cnt", done_cnt_a, 2);

        // Start while busy is ignored; start in FINISH ignored; start in following IDLE runs
        clear_a();
        start_a = 1; tick(); start_a = 0;
        wait_present_a(7'd1, "t3");
        start_a = 1; tick(); start_a = 0;
        wait_done(0, 40, "t3");
        check_seq_a("t3");
        start_a = 1;
        tick();
        chk("t3_finish_start_ignored", busy_a, 0);
        tick();
        start_a = 0;
        chk("t3_restart_busy", busy_a, 1);
        chk("t3_restart_index", mem_index_a, 0);
        clear_a();
        wait_done(0, 40, "t3b");
        tick();
        check_seq_a("t3b");
        chk("t3_done_cnt", done_cnt_a, 4);

        // Wrapping window
        start_w = 1; tick(); start_w = 0;
        wait_done(1, 40, "t4");
        tick();
        chk("t4_count", dat_w.size(), 4);
        for (int i = 0; i < 4 && i < dat_w.size(); i++) begin
            chk($sformatf("t4_idx%0d", i), idx_w[i], exp_w_idx[i]);
            chk($sformatf("t4_data%0d", i), dat_w[i], exp_w_dat[i]);
            chk($sformatf("t4_last%0d", i), lst_w[i], (i == 3));
        end
        chk("t4_done_cnt", done_cnt_w, 1);

        // Full 128-word window
        start_f = 1; tick(); start_f = 0;
        wait_done(2, 500, "t5");
        tick();
        chk("t5_count", dat_f.size(), 128);
        bad_idx = 0; bad_dat = 0; n_last = 0;
        for (int i = 0; i < dat_f.size(); i++) begin
            if (idx_f[i] !== 7'(i)) bad_idx++;
            if (dat_f[i] !== 32'(i * 3 + 1)) bad_dat++;
            if (lst_f[i]) n_last++;
        end
        chk("t5_bad_idx", bad_idx, 0);
        chk("t5_bad_data", bad_dat, 0);
        chk("t5_last_count", n_last, 1);
        if (dat_f.size() == 128) chk("t5_last_at_127", lst_f[127], 1);
        chk("t5_done_cnt", done_cnt_f, 1);

        // Asynchronous reset mid-run
        clear_a();
        saved_done = done_cnt_a;
        start_a = 1; tick(); start_a = 0;
        wait_present_a(7'd1, "t6");
        #3 rst = 1'b0;
        #1;
        chk("t6_rst_valid", valid_a, 0);
        chk("t6_rst_busy", busy_a, 0);
        chk("t6_rst_mem_rd", mem_rd_a, 0);
        chk("t6_rst_mem_index", mem_index_a, 0);
        chk("t6_rst_data", data_a, 0);
        chk("t6_rst_out_index", index_a, 0);
        chk("t6_rst_last", last_a, 0);
        chk("t6_rst_rd_done", rd_done_a, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t6_no_partial_done", done_cnt_a, saved_done);
        chk("t6_idle_after_rst", busy_a, 0);
        clear_a();
        start_a = 1; tick(); start_a = 0;
        wait_done(0, 40, "t6");
        tick();
        check_seq_a("t6");
        chk("t6_done_cnt", done_cnt_a, saved_done + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
